tile_reader: RTL
================

TILE_READER -- requirements
Module: tile_reader

Interface
REQ-001 Parameter MAX_PENDING, default 8: maximum words outstanding on the bus plus words held in the response buffer (power of two, 2..16).
REQ-002 clk  input  1  single clock; all logic rising-edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  begin loading one 32x32 RGB565 tile; sampled only in S_IDLE.
REQ-005 addr_in  input  32  byte address of the tile's top-left pixel; captured on accepted start.
REQ-006 stride_in  input  16  framebuffer row pitch in bytes; captured on accepted start.
REQ-007 busy  output  1  high in every state except S_IDLE.
REQ-008 done  output  1  one-cycle pulse after the final tile RAM write.
REQ-009 ram_addr_out  output  10  tile RAM write address (pixel index, row-major, 32 pixels/row).
REQ-010 ram_data_out  output  16  tile RAM write data.
REQ-011 ram_wren  output  1  tile RAM write enable, one pixel per asserted cycle.
REQ-012 master_address  output  32  Avalon-MM read byte address.
REQ-013 master_read  output  1  Avalon-MM read request.
REQ-014 master_read_data  input  32  read data; bits [15:0] = even pixel, [31:16] = odd pixel.
REQ-015 master_read_data_valid  input  1  read data valid (pipelined reads, in order).
REQ-016 master_wait_request  input  1  slave stall; request held stable while high.

Function
REQ-017 States: S_IDLE, S_READ (issuing requests), S_DRAIN (all 512 requests accepted, awaiting data/unpack), S_DONE (one cycle, drives done).
REQ-018 S_IDLE -> S_READ on start; start while busy is ignored.
REQ-019 Tile = 32 rows x 16 words; word address +4 within a row; after word 15 of a row next address = row base + stride (row base = addr_in + row*stride, 32-bit wrap-around arithmetic, stride zero-extended).
REQ-020 master_read asserts the cycle after start is accepted, earliest.
REQ-021 A request is accepted when master_read && !master_wait_request; address and read held stable until accepted.
REQ-022 master_read asserts only when pending+buffered < MAX_PENDING; counter increments on accept, decrements on buffer pop; simultaneous accept and pop leaves it unchanged.
REQ-023 Every master_read_data_valid beat is written into the response buffer unconditionally; REQ-022 guarantees space; overflow is a design error flagged by assertion.
REQ-024 S_READ -> S_DRAIN on acceptance of request 512; master_read low thereafter.
REQ-025 Unpack: pop one word, write [15:0] to pixel 2k, next cycle write [31:16] to pixel 2k+1; ram_addr_out increments by 1 per write, 0..1023, in arrival order.
REQ-026 Unpack runs concurrently with S_READ and S_DRAIN; peak rate one pixel per cycle.
REQ-027 S_DRAIN -> S_DONE the cycle after the write of pixel 1023; S_DONE -> S_IDLE unconditionally; done high only in S_DONE.
REQ-028 A new start is accepted in the cycle after S_DONE.

Reset
REQ-029 On rst: state S_IDLE, busy 0, done 0, ram_wren 0, master_read 0, master_address 0, ram_addr_out 0, ram_data_out 0, counters 0, response buffer empty.
REQ-030 Reset mid-operation abandons the tile immediately; read data arriving after reset release is discarded.

Structure
REQ-031 Package gpu_tile_pkg holds TILE_W=32, TILE_H=32, WORDS_PER_ROW=16, TILE_WORDS=512, TILE_PIXELS=1024, and the state enum; shared with the tile write-back stage.
REQ-032 One sub-module, tile_resp_fifo: synchronous FIFO, 32-bit, depth MAX_PENDING, async-reset, with full/empty/count outputs.

Verification
REQ-033 addr_in=0x1000_0000, stride_in=2048, zero-wait slave, 1-cycle latency -> 512 reads at 0x1000_0000..0x1000_003C, then 0x1000_0800..; RAM[n] matches memory pattern; single done pulse.
REQ-034 Slave latency 20 cycles, MAX_PENDING=8 -> never more than 8 outstanding reads; all 1024 pixels correct.
REQ-035 Random master_wait_request (50%) -> master_address/master_read stable during every stall; no lost or duplicated addresses.
REQ-036 Word 0xBEEF_1234 as first word -> RAM[0]=0x1234, RAM[1]=0xBEEF, on consecutive ram_wren cycles.
REQ-037 rst asserted after 100 accepted reads, released with 4 responses still in flight -> outputs at reset values, no ram_wren, next start loads a full correct tile.
REQ-038 start pulsed while busy, addr_in=0xFFFF_FFC0 with stride 64 -> second start ignored; addresses wrap modulo 2^32.

Source files
------------

// File: rtl/gpu_tile_pkg.sv
// rtl/gpu_tile_pkg.sv - tile geometry constants and state type shared by tile load/write-back stages
package gpu_tile_pkg;
   localparam int TILE_W        = 32;
   localparam int TILE_H        = 32;
   localparam int WORDS_PER_ROW = 16;
   localparam int TILE_WORDS    = 512;
   localparam int TILE_PIXELS   = 1024;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } tile_state_e;
endpackage

// File: rtl/tile_resp_fifo.sv
// rtl/tile_resp_fifo.sv - show-ahead synchronous FIFO buffering read responses
module tile_resp_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_wr_en,
   input  logic [WIDTH-1:0]         i_wr_data,
   input  logic                     i_rd_en,
   output logic [WIDTH-1:0]         o_rd_data,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             w_wr;
   logic             w_rd;

   assign o_full    = (r_count == CW'(DEPTH));
   assign o_empty   = (r_count == '0);
   assign o_count   = r_count;
   assign o_rd_data = r_mem[r_rd_ptr];
   assign w_wr      = i_wr_en && !o_full;
   assign w_rd      = i_rd_en && !o_empty;

   always_ff @(posedge clk) begin
      if (w_wr) begin
         r_mem[r_wr_ptr] <= i_wr_data;
      end
   end

   // DEPTH is a power of two, so the pointers wrap on their own
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
         r_count <= r_count + CW'(w_wr) - CW'(w_rd);
      end
   end
endmodule

// File: rtl/tile_reader.sv
// rtl/tile_reader.sv - fetches one 32x32 RGB565 tile over Avalon-MM into tile RAM
module tile_reader
   import gpu_tile_pkg::*;
#(
   parameter int MAX_PENDING = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] addr_in,
   input  logic [15:0] stride_in,
   output logic        busy,
   output logic        done,
   output logic [9:0]  ram_addr_out,
   output logic [15:0] ram_data_out,
   output logic        ram_wren,
   output logic [31:0] master_address,
   output logic        master_read,
   input  logic [31:0] master_read_data,
   input  logic        master_read_data_valid,
   input  logic        master_wait_request
);
   localparam int PW = $clog2(MAX_PENDING) + 1;
   localparam logic [PW-1:0] C_MAX = PW'(MAX_PENDING);

   tile_state_e r_state;
   logic [31:0] r_addr;
   logic [31:0] r_row_base;
   logic [31:0] r_stride;
   logic [9:0]  r_req_cnt;
   logic [9:0]  r_pix;
   logic [9:0]  r_ram_addr;
   logic [15:0] r_ram_data;
   logic [15:0] r_hi;
   logic        r_half;
   logic        r_wren;
   logic [PW-1:0] r_pending;
   logic [PW-1:0] r_outstd;

   logic          w_accept;
   logic          w_fifo_wr;
   logic          w_pop;
   logic          w_start;
   logic          w_fifo_full;
   logic          w_fifo_empty;
   logic [31:0]   w_fifo_data;
   logic [PW-1:0] w_fifo_count;

   assign busy           = (r_state != S_IDLE);
   assign done           = (r_state == S_DONE);
   assign master_read    = (r_state == S_READ) && (r_pending < C_MAX);
   assign master_address = r_addr;
   assign ram_addr_out   = r_ram_addr;
   assign ram_data_out   = r_ram_data;
   assign ram_wren       = r_wren;

   assign w_start   = (r_state == S_IDLE) && start;
   assign w_accept  = master_read && !master_wait_request;
   // beats with no matching request (e.g. left over from before a reset) are dropped
   assign w_fifo_wr = master_read_data_valid && (r_outstd != '0);
   assign w_pop     = !r_half && !w_fifo_empty;

   tile_resp_fifo #(.WIDTH(32), .DEPTH(MAX_PENDING)) u_resp_fifo (
      .clk       (clk),
      .rst       (rst),
      .i_wr_en   (w_fifo_wr),
      .i_wr_data (master_read_data),
      .i_rd_en   (w_pop),
      .o_rd_data (w_fifo_data),
      .o_full    (w_fifo_full),
      .o_empty   (w_fifo_empty),
      .o_count   (w_fifo_count)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_addr     <= '0;
         r_row_base <= '0;
         r_stride   <= '0;
         r_req_cnt  <= '0;
      end else begin
         case (r_state)
            S_IDLE: if (start) begin
               r_state    <= S_READ;
               r_addr     <= addr_in;
               r_row_base <= addr_in;
               r_stride   <= {16'd0, stride_in};
               r_req_cnt  <= '0;
            end
            S_READ: if (w_accept) begin
               r_req_cnt <= r_req_cnt + 10'd1;
               if (r_req_cnt[3:0] == 4'hF) begin
                  r_row_base <= r_row_base + r_stride;
                  r_addr     <= r_row_base + r_stride;
               end else begin
                  r_addr <= r_addr + 32'd4;
               end
               if (r_req_cnt == 10'(TILE_WORDS - 1)) r_state <= S_DRAIN;
            end
            S_DRAIN: if (r_wren && (r_ram_addr == 10'(TILE_PIXELS - 1))) r_state <= S_DONE;
            S_DONE:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // pending covers words on the bus plus words waiting in the buffer
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pending <= '0;
         r_outstd  <= '0;
      end else begin
         r_pending <= r_pending + PW'(w_accept) - PW'(w_pop);
         r_outstd  <= r_outstd + PW'(w_accept) - PW'(w_fifo_wr);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wren     <= 1'b0;
         r_ram_addr <= '0;
         r_ram_data <= '0;
         r_hi       <= '0;
         r_half     <= 1'b0;
         r_pix      <= '0;
      end else begin
         r_wren <= 1'b0;
         if (w_start) begin
            r_pix  <= '0;
            r_half <= 1'b0;
         end else if (w_pop) begin
            r_wren     <= 1'b1;
            r_ram_addr <= r_pix;
            r_ram_data <= w_fifo_data[15:0];
            r_hi       <= w_fifo_data[31:16];
            r_pix      <= r_pix + 10'd1;
            r_half     <= 1'b1;
         end else if (r_half) begin
            r_wren     <= 1'b1;
            r_ram_addr <= r_pix;
            r_ram_data <= r_hi;
            r_pix      <= r_pix + 10'd1;
            r_half     <= 1'b0;
         end
      end
   end

   a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(w_fifo_wr && w_fifo_full));
   a_count_bound: assert property (@(posedge clk) disable iff (rst) w_fifo_count <= r_pending);
endmodule
